// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit that owns HI/LO and serves mfhi/mflo combinationally.
// The result is committed MULT_CYCLES/DIV_CYCLES after launch; busy stalls the controller and all starts are ignored while busy.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [2:0]  mdOp,
  input  logic        start,
  input  logic        rdSel,
  output logic [31:0] rdData,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [4:0] MCYC     = 5'(MULT_CYCLES);
  localparam logic [4:0] DCYC     = 5'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [4:0]         counter;
  logic [31:0]        pend_hi, pend_lo;
  logic [31:0]        res_hi, res_lo;
  logic               launch, is_mul, is_div;
  logic signed [31:0] sa, sdiv, sq, sr;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        udiv;
  logic               div_zero, div_ovf;

  assign is_mul   = (mdOp == OP_MULT) || (mdOp == OP_MULTU);
  assign is_div   = (mdOp == OP_DIV)  || (mdOp == OP_DIVU);
  assign launch   = (state == IDLE) && start && (is_mul || is_div);
  assign busy     = (state == BUSY);
  assign rdData   = rdSel ? hi : lo;

  // A zero divisor is replaced by 1 so the dividers never see it; the result is discarded anyway.
  assign div_zero = (dataB == 32'd0);
  assign div_ovf  = (dataA == 32'h8000_0000) && (dataB == 32'hFFFF_FFFF);
  assign udiv     = div_zero ? 32'd1 : dataB;
  assign sa       = $signed(dataA);
  assign sdiv     = $signed(udiv);
  assign sq       = sa / sdiv;
  assign sr       = sa % sdiv;
  assign prod_s   = $signed(dataA) * $signed(dataB);
  assign prod_u   = {32'd0, dataA} * {32'd0, dataB};

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (mdOp)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else if (!div_zero) begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      OP_DIVU: begin
        if (!div_zero) begin
          res_hi = dataA % udiv;
          res_lo = dataA / udiv;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (launch) state_nxt = BUSY;
      BUSY: if (counter <= 5'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= 5'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        counter <= is_mul ? MCYC : DCYC;
        pend_hi <= res_hi;
        pend_lo <= res_lo;
      end else if (state == BUSY) begin
        counter <= counter - 5'd1;
        if (counter <= 5'd1) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end else if (start && mdOp == OP_MTHI) begin
        hi <= dataA;
      end else if (start && mdOp == OP_MTLO) begin
        lo <= dataA;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: expected HI/LO pushed on launch, popped and compared at writeback.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB;
  logic [2:0]  mdOp;
  logic        start, rdSel;
  logic [31:0] rdData, hi, lo;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .mdOp(mdOp),
    .start(start), .rdSel(rdSel), .rdData(rdData), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch an op, watch busy length and held registers, then compare writeback against the scoreboard.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int ncyc, input logic [63:0] expv,
                        input bit disturb);
    logic [31:0] old_hi, old_lo;
    logic [63:0] e;
    int n;
    @(negedge clk);
    old_hi = hi;
    old_lo = lo;
    dataA = a; dataB = b; mdOp = op; start = 1'b1;
    sb.push_back(expv);
    @(negedge clk);
    start = 1'b0; mdOp = 3'b000;
    n = 0;
    while (busy && n < 64) begin
      n++;
      if (n == 1) begin
        check({tag, "_hold_hi"}, hi, old_hi);
        check({tag, "_hold_lo"}, lo, old_lo);
      end
      if (disturb && n == 2) begin
        dataA = 32'h0000_00AA; dataB = 32'h0000_0003; mdOp = 3'b101; start = 1'b1;
      end else begin
        start = 1'b0; mdOp = 3'b000;
      end
      @(negedge clk);
    end
    start = 1'b0; mdOp = 3'b000;
    check({tag, "_busy_len"}, 32'(n), 32'(ncyc));
    e = sb.pop_front();
    check({tag, "_hi"}, hi, e[63:32]);
    check({tag, "_lo"}, lo, e[31:0]);
  endtask

  task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] v);
    logic [31:0] old_hi, old_lo;
    @(negedge clk);
    old_hi = hi; old_lo = lo;
    dataA = v; mdOp = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mdOp = 3'b000;
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_hi"}, hi, (op == 3'b101) ? v : old_hi);
    check({tag, "_lo"}, lo, (op == 3'b110) ? v : old_lo);
  endtask

  initial begin
    reset = 1'b1; dataA = 32'hDEAD_BEEF; dataB = 32'h1; mdOp = 3'b001; start = 1'b1; rdSel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; mdOp = 3'b000;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd", rdData, 32'd0);

    run_op("mult", 3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 5, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
    run_op("multu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 64'hFFFF_FFFE_0000_0001, 1'b1);
    run_op("div", 3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 10, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000, 1'b0);

    move_to("mthi11", 3'b101, 32'h0000_0011);
    move_to("mtlo22", 3'b110, 32'h0000_0022);
    run_op("divu_z", 3'b100, 32'd100, 32'd0, 10, 64'h0000_0011_0000_0022, 1'b0);
    run_op("divu", 3'b100, 32'd100, 32'd7, 10, {32'd2, 32'd14}, 1'b0);
    run_op("div_pos_neg", 3'b011, 32'd7, 32'hFFFF_FFFE, 10, 64'h0000_0001_FFFF_FFFD, 1'b0);

    // start with a "none" opcode must not touch anything
    @(negedge clk);
    mdOp = 3'b111; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mdOp = 3'b000;
    check("none_busy", 32'(busy), 32'd0);
    check("none_hi", hi, 32'd1);
    check("none_lo", lo, 32'hFFFF_FFFD);

    move_to("mthi", 3'b101, 32'h1234_5678);
    rdSel = 1'b1;
    #1 check("rd_hi", rdData, 32'h1234_5678);
    rdSel = 1'b0;
    #1 check("rd_lo", rdData, 32'hFFFF_FFFD);

    // abort a mult with reset on its third busy cycle
    @(negedge clk);
    dataA = 32'd3; dataB = 32'd4; mdOp = 3'b001; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mdOp = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("abort_late_busy", 32'(busy), 32'd0);
    check("abort_late_hi", hi, 32'd0);
    check("abort_late_lo", lo, 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
